// File: rtl/serial_alu_seq.sv
// Nibble-serial sequencer for a 4-bit add/sub ALU.
// Takes one wide command, runs it through the external ALU LSB nibble first, and returns the sum with C/Z/V flags.
module serial_alu_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_ci,
    input  logic [3:0]             alu_s,
    input  logic                   alu_co,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_s,
    output logic                   out_co,
    output logic                   out_z,
    output logic                   out_v
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           op_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   res;
    logic [W-1:0]   res_next;
    logic           last_nibble;

    assign last_nibble = (idx == IW'(NIBBLES - 1));
    assign out_s       = res;
    assign out_valid   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The ALU inverts B itself when ci=1, so B is pre-inverted whenever op and carry disagree;
    // this yields A + B + carry for add and A + ~B + carry for subtract.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        alu_a      = 4'h0;
        alu_b      = 4'h0;
        alu_ci     = 1'b0;
        res_next   = res;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                alu_a  = a_reg[{idx, 2'b00} +: 4];
                alu_b  = b_reg[{idx, 2'b00} +: 4] ^ {4{op_reg ^ carry}};
                alu_ci = carry;
                res_next[{idx, 2'b00} +: 4] = alu_s;
                if (last_nibble) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            op_reg <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            res    <= '0;
            out_co <= 1'b0;
            out_z  <= 1'b0;
            out_v  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= in_a;
                        b_reg  <= in_b;
                        op_reg <= in_op;
                        idx    <= '0;
                        carry  <= in_op;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= alu_co;
                    idx   <= idx + 1'b1;
                    // Flags are taken from the top nibble on the final RUN edge.
                    if (last_nibble) begin
                        out_co <= alu_co;
                        out_z  <= (res_next == '0);
                        if (op_reg) begin
                            out_v <= (a_reg[W-1] != b_reg[W-1]) && (alu_s[3] != a_reg[W-1]);
                        end else begin
                            out_v <= (a_reg[W-1] == b_reg[W-1]) && (alu_s[3] != a_reg[W-1]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
